display_fetch_scheduler: RTL
============================

Name: display_fetch_scheduler

Overview:
Scheduling controller between the 640x480 video timing generator and the framebuffer memory port. Keys off line_start/pixel_y to issue one line-fetch request per scanline, one line ahead, into a ping-pong line buffer. Performs front/back framebuffer swap at vblank entry on renderer request. Flags lines whose fetch did not complete in time (underrun).

Parameters:
H_ACTIVE, 640, pixels per line; also the fetch length in pixel words
V_ACTIVE, 480, visible lines
V_TOTAL, 525, total lines per frame
ADDR_W, 24, memory byte-address width
LINE_STRIDE, 1280, bytes between consecutive framebuffer lines
FB0_BASE, 24'h000000, byte base address of framebuffer 0
FB1_BASE, 24'h096000, byte base address of framebuffer 1

Ports:
clk_pixel  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
line_start  in  1  one-cycle pulse at h_count==0 from the timing generator
pixel_y  in  10  current line index, valid when line_start is high
swap_request  in  1  level; renderer has a finished back buffer
swap_done  out  1  one-cycle pulse when the swap takes effect
front_sel  out  1  framebuffer being displayed (0=FB0, 1=FB1)
fetch_req  out  1  fetch request valid
fetch_ack  in  1  memory side accepts the request when fetch_req&&fetch_ack
fetch_addr  out  ADDR_W  byte address of the line start
fetch_len  out  10  pixel words to fetch, always H_ACTIVE
fetch_buf  out  1  destination line-buffer half, equals target line LSB
fetch_done  in  1  one-cycle pulse when the accepted fetch has fully landed
line_ready  out  1  line buffer for the current displayed line is valid
underrun  out  1  sticky; set on any underrun
underrun_count  out  16  saturating underrun counter (see Optional Feature)

Behaviour:
- Reset values: fetch_req=0, fetch_addr=0, fetch_buf=0, fetch_len=H_ACTIVE, front_sel=0, swap_done=0, line_ready=0, underrun=0, underrun_count=0, armed=0, state=IDLE.
- FSM states: IDLE, REQ, WAIT.
  - IDLE to REQ: a fetch is scheduled.
  - REQ to WAIT: fetch_req&&fetch_ack.
  - WAIT to IDLE: fetch_done.
  - fetch_done is ignored outside WAIT.
- Scheduling on line_start with pixel_y=y:
  - y<V_ACTIVE-1: target y+1.
  - y==V_TOTAL-1: target 0.
  - Otherwise: no fetch.
- Issuing a fetch: fetch_req rises the cycle after line_start. fetch_addr = base(front_sel) + target*LINE_STRIDE, truncated mod 2^ADDR_W. fetch_buf=target[0]. addr, buf and len are held stable while fetch_req=1.
- Line-0 fetch sets armed=1. Armed stays 1 until reset.
- Completion tracking: a done_tgt register records the last completed target line and updates on fetch_done in WAIT.
- Line check on line_start with y<V_ACTIVE and armed=1:
  - Fetch for y complete (state==IDLE and done_tgt==y): line_ready=1 for the line.
  - Otherwise: line_ready=0, underrun is set, underrun_count increments (saturating at 16'hFFFF).
- With armed=0, line_ready=0 and no underrun is recorded. This covers the partial first frame after reset.
- line_ready=0 during vblank lines.
- Collision: if a new fetch is scheduled while state!=IDLE, the outstanding fetch is not aborted. The new fetch is dropped, and the corresponding line underruns at its own line check.
- Swap: on line_start with y==V_ACTIVE and swap_request=1, front_sel toggles and swap_done pulses for one cycle, both in the cycle after line_start. The next line-0 fetch uses the new base. swap_request=0 at that point means no swap; a request asserted mid-frame waits for the next vblank.
- Reset mid-fetch: all state clears immediately and fetch_req drops asynchronously. The memory side must discard the in-flight transfer.

Optional Feature:
DISPLAY_FETCH_STATS_EN.
- Defined: underrun_count implemented as above.
- Undefined: underrun_count is tied to 16'd0 with no counter logic. The sticky underrun flag is unaffected.

Test Plan:
- Reset, then a full frame with fetch_ack=1 and fetch_done 100 cycles after accept -> first line-0 fetch at y=524 with addr 0x000000 and buf 0. Line 1 fetch addr 0x000500. Line 479 fetch addr 0x095B00 and buf 1. line_ready=1 on all 480 lines of the following frame; underrun=0.
- First partial frame after reset, starting at y=0 -> line_ready=0 and underrun_count stays 0 until the line-0 fetch completes.
- fetch_ack held low for 900 cycles on the line-5 fetch -> fetch_req and fetch_addr stable throughout. Line 5 underruns: underrun=1, count=1. Line-6 fetch dropped, so line 6 also underruns: count=2.
- swap_request=1 asserted at y=200 -> swap_done pulses once, the cycle after line_start at y=480. front_sel=1. Next line-0 fetch addr 0x096000.
- swap_request=0 at y=480 -> no swap_done, front_sel unchanged, addresses remain FB0-based.
- rst_n asserted low while in WAIT -> fetch_req=0 and all outputs at reset values. After release, the next fetch occurs only at y=524.

Source files
------------

// File: rtl/display_fetch_scheduler_if.sv
// Framebuffer line-fetch port between the display scheduler and the memory side.
// Latency: none, wires only.
// Backpressure: the request is held by the master until the slave raises fetch_ack.
interface display_fetch_scheduler_if #(
    parameter int ADDR_W = 24
) ();
    logic              fetch_req;
    logic              fetch_ack;
    logic [ADDR_W-1:0] fetch_addr;
    logic [9:0]        fetch_len;
    logic              fetch_buf;
    logic              fetch_done;

    modport master (
        output fetch_req, fetch_addr, fetch_len, fetch_buf,
        input  fetch_ack, fetch_done
    );

    modport slave (
        input  fetch_req, fetch_addr, fetch_len, fetch_buf,
        output fetch_ack, fetch_done
    );
endinterface

// File: rtl/display_fetch_scheduler.sv
// Line-fetch scheduler: one framebuffer line fetch per scanline, one line ahead, with vblank buffer swap and underrun flagging.
// Latency: fetch_req rises the cycle after line_start; swap_done/front_sel and line_ready update the cycle after line_start.
// Backpressure: request and its address/buffer/length are held until fetch_ack; fetches scheduled while busy are dropped.
// Optional: define DISPLAY_FETCH_STATS_EN to build the saturating underrun counter (otherwise underrun_count reads 0).
module display_fetch_scheduler #(
    parameter int              H_ACTIVE    = 640,
    parameter int              V_ACTIVE    = 480,
    parameter int              V_TOTAL     = 525,
    parameter int              ADDR_W      = 24,
    parameter int              LINE_STRIDE = 1280,
    parameter logic [ADDR_W-1:0] FB0_BASE  = 24'h000000,
    parameter logic [ADDR_W-1:0] FB1_BASE  = 24'h096000
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic [9:0]  pixel_y,
    input  logic        swap_request,
    output logic        swap_done,
    output logic        front_sel,
    output logic        line_ready,
    output logic        underrun,
    output logic [15:0] underrun_count,
    display_fetch_scheduler_if.master fetch
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    localparam logic [9:0] Y_LAST_FETCH = 10'(V_ACTIVE - 1);
    localparam logic [9:0] Y_VBLANK     = 10'(V_ACTIVE);
    localparam logic [9:0] Y_LAST       = 10'(V_TOTAL - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              buf_q;
    logic [9:0]        tgt_q;       // target line of the outstanding fetch
    logic [9:0]        done_tgt_q;  // last target line whose data has landed
    logic              armed_q;
    logic              front_sel_q;
    logic              swap_done_q;
    logic              line_ready_q;
    logic              underrun_q;

    logic              sched_en;
    logic              issue;
    logic [9:0]        sched_tgt;
    logic [ADDR_W-1:0] sched_addr;
    logic              line_chk;
    logic              line_ok;
    logic              underrun_hit;
    logic              swap_now;

    // Visible-line fetches only start once the line-0 fetch has armed the
    // pipeline, so the partial frame after reset issues nothing until y=V_TOTAL-1.
    assign sched_en   = line_start && (((pixel_y < Y_LAST_FETCH) && armed_q) || (pixel_y == Y_LAST));
    assign sched_tgt  = (pixel_y == Y_LAST) ? 10'd0 : pixel_y + 10'd1;
    assign issue      = sched_en && (state_q == S_IDLE);
    assign sched_addr = (front_sel_q ? FB1_BASE : FB0_BASE)
                        + ADDR_W'(32'(sched_tgt) * LINE_STRIDE);

    assign line_chk     = line_start && (pixel_y < Y_VBLANK) && armed_q;
    assign line_ok      = (state_q == S_IDLE) && (done_tgt_q == pixel_y);
    assign underrun_hit = line_chk && !line_ok;
    assign swap_now     = line_start && (pixel_y == Y_VBLANK) && swap_request;

    // Fetch state register.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and request output; fetch_done is only honoured in S_WAIT.
    always_comb begin
        state_d         = state_q;
        fetch.fetch_req = 1'b0;
        unique case (state_q)
            S_IDLE: if (issue) state_d = S_REQ;
            S_REQ: begin
                fetch.fetch_req = 1'b1;
                if (fetch.fetch_ack) state_d = S_WAIT;
            end
            S_WAIT: if (fetch.fetch_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request payload, completion tracking, arming, line check and swap.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            buf_q        <= 1'b0;
            tgt_q        <= '0;
            done_tgt_q   <= '1;
            armed_q      <= 1'b0;
            front_sel_q  <= 1'b0;
            swap_done_q  <= 1'b0;
            line_ready_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            if (issue) begin
                addr_q <= sched_addr;
                buf_q  <= sched_tgt[0];
                tgt_q  <= sched_tgt;
                if (sched_tgt == 10'd0) armed_q <= 1'b1;
            end
            if ((state_q == S_WAIT) && fetch.fetch_done) done_tgt_q <= tgt_q;
            if (line_start) line_ready_q <= line_chk && line_ok;
            if (underrun_hit) underrun_q <= 1'b1;
            swap_done_q <= swap_now;
            if (swap_now) front_sel_q <= ~front_sel_q;
        end
    end

`ifdef DISPLAY_FETCH_STATS_EN
    logic [15:0] underrun_cnt_q;

    // Saturating count of lines that were not ready at their line check.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n)                                     underrun_cnt_q <= '0;
        else if (underrun_hit && (underrun_cnt_q != 16'hFFFF)) underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end

    assign underrun_count = underrun_cnt_q;
`else
    assign underrun_count = 16'd0;
`endif

    assign fetch.fetch_addr = addr_q;
    assign fetch.fetch_buf  = buf_q;
    assign fetch.fetch_len  = 10'(H_ACTIVE);
    assign swap_done        = swap_done_q;
    assign front_sel        = front_sel_q;
    assign line_ready       = line_ready_q;
    assign underrun         = underrun_q;
endmodule
